// File: rtl/csr_trap_unit_if.sv
// Commit-side bus between the control unit and csr_trap_unit.
// master: control unit (drives the instruction strobes and operands, reads the results)
// slave : csr_trap_unit (reads the strobes, drives csrReadData/redirect/retire)
interface csr_trap_unit_if;
  logic        instValid;
  logic [31:0] pc;
  logic [11:0] csrAddr;
  logic [31:0] rs1Data;
  logic [4:0]  zimm;
  logic        csrWrite;
  logic [1:0]  csrInstType;
  logic        csrImmInst;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        irqExt;
  logic        irqTimer;
  logic [31:0] csrReadData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        retire;

  modport master (
    output instValid, pc, csrAddr, rs1Data, zimm, csrWrite, csrInstType, csrImmInst,
           ecall, ebreak, mret, irqExt, irqTimer,
    input  csrReadData, redirectValid, redirectPc, retire
  );

  modport slave (
    input  instValid, pc, csrAddr, rs1Data, zimm, csrWrite, csrInstType, csrImmInst,
           ecall, ebreak, mret, irqExt, irqTimer,
    output csrReadData, redirectValid, redirectPc, retire
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, 64-bit cycle/instret counters and trap/mret sequencer.
// Ports:
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : csr_trap_unit_if.slave -- commit strobes/operands in,
//              csrReadData (pre-write CSR value), redirectValid/redirectPc, retire out.
//              Outputs are combinational in the commit cycle; state updates on the edge.
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  csr_trap_unit_if.slave bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 64;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] CAUSE_MEI  = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_MTI  = 32'h8000_0007;
  localparam logic [XLEN-1:0] CAUSE_BRK  = 32'h0000_0003;
  localparam logic [XLEN-1:0] CAUSE_ECL  = 32'h0000_000B;

  // Architectural state
  logic            r_mst_mie;
  logic            r_mst_mpie;
  logic            r_mie_meie;
  logic            r_mie_mtie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [CNTW-1:0] r_mcycle;
  logic [CNTW-1:0] r_minstret;

  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;
  logic [XLEN-1:0] w_cause;
  logic            w_commit;
  logic            w_ext;
  logic            w_tmr;
  logic            w_int_take;
  logic            w_trap;
  logic            w_mret;
  logic            w_retire;
  logic            w_csr_we;

  // CSR read mux: always the pre-write value
  always_comb begin
    w_old = '0;
    case (bus.csrAddr)
      A_MSTATUS:   w_old = {24'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};
      A_MIE:       w_old = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
      A_MTVEC:     w_old = r_mtvec;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MIP:       w_old = {20'b0, bus.irqExt, 3'b0, bus.irqTimer, 7'b0};
      A_MCYCLE:    w_old = r_mcycle[31:0];
      A_MCYCLEH:   w_old = r_mcycle[63:32];
      A_MINSTRET:  w_old = r_minstret[31:0];
      A_MINSTRETH: w_old = r_minstret[63:32];
      default:     w_old = '0;
    endcase
  end

  // Read-modify-write value
  always_comb begin
    w_src = bus.csrImmInst ? {27'b0, bus.zimm} : bus.rs1Data;
    case (bus.csrInstType)
      2'b00:   w_new = w_src;
      2'b01:   w_new = w_old | w_src;
      2'b10:   w_new = w_old & ~w_src;
      default: w_new = w_old;
    endcase
  end

  // Trap decision; everything is suppressed while rst is high
  assign w_commit   = bus.instValid & ~rst;
  assign w_ext      = r_mst_mie & bus.irqExt   & r_mie_meie;
  assign w_tmr      = r_mst_mie & bus.irqTimer & r_mie_mtie;
  assign w_int_take = w_commit & (w_ext | w_tmr);
  assign w_trap     = w_int_take | (w_commit & (bus.ecall | bus.ebreak));
  assign w_mret     = w_commit & ~w_trap & bus.mret;
  assign w_retire   = w_commit & ~w_int_take & ~bus.ecall & ~bus.ebreak;
  assign w_csr_we   = w_commit & bus.csrWrite & ~w_trap & (bus.csrInstType != 2'b11);

  always_comb begin
    if (w_ext)            w_cause = CAUSE_MEI;
    else if (w_tmr)       w_cause = CAUSE_MTI;
    else if (bus.ebreak)  w_cause = CAUSE_BRK;
    else                  w_cause = CAUSE_ECL;
  end

  assign bus.csrReadData   = w_old;
  assign bus.redirectValid = w_trap | w_mret;
  assign bus.redirectPc    = w_trap ? r_mtvec : r_mepc;
  assign bus.retire        = w_retire;

  // State update: trap > mret > CSR write for mstatus; CSR write beats increment for counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
      r_mie_meie <= 1'b0;
      r_mie_mtie <= 1'b0;
      r_mtvec    <= RESET_MTVEC & ALIGN_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_trap) begin
        r_mst_mpie <= r_mst_mie;
        r_mst_mie  <= 1'b0;
      end else if (w_mret) begin
        r_mst_mie  <= r_mst_mpie;
        r_mst_mpie <= 1'b1;
      end else if (w_csr_we && bus.csrAddr == A_MSTATUS) begin
        r_mst_mie  <= w_new[3];
        r_mst_mpie <= w_new[7];
      end

      if (w_csr_we && bus.csrAddr == A_MIE) begin
        r_mie_meie <= w_new[11];
        r_mie_mtie <= w_new[7];
      end

      if (w_csr_we && bus.csrAddr == A_MTVEC)    r_mtvec    <= w_new & ALIGN_MASK;
      if (w_csr_we && bus.csrAddr == A_MSCRATCH) r_mscratch <= w_new;

      if (w_trap) begin
        r_mepc   <= bus.pc & ALIGN_MASK;
        r_mcause <= w_cause;
      end else begin
        if (w_csr_we && bus.csrAddr == A_MEPC)   r_mepc   <= w_new & ALIGN_MASK;
        if (w_csr_we && bus.csrAddr == A_MCAUSE) r_mcause <= w_new;
      end

      // Writing either half freezes the other half for that cycle
      if (w_csr_we && bus.csrAddr == A_MCYCLE)       r_mcycle[31:0]  <= w_new;
      else if (w_csr_we && bus.csrAddr == A_MCYCLEH) r_mcycle[63:32] <= w_new;
      else                                           r_mcycle        <= r_mcycle + 64'd1;

      if (w_csr_we && bus.csrAddr == A_MINSTRET)       r_minstret[31:0]  <= w_new;
      else if (w_csr_we && bus.csrAddr == A_MINSTRETH) r_minstret[63:32] <= w_new;
      else if (w_retire)                               r_minstret        <= r_minstret + 64'd1;
    end
  end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap sequencer sitting directly downstream of the control unit in the Hunter_RV32 core. It consumes the decoded `csrWrite`, `csrInstType`, `csrImmInst`, `ecall`, `ebreak` and `mret` strobes together with the committing instruction's PC and operands. It holds the M-mode CSRs plus the 64-bit cycle and retired-instruction counters. It returns the CSR read value for the `RF_CSR` write-back path and a PC redirect for traps and `mret`.

## Interface

**Parameters**
- `RESET_MTVEC`, default `32'h0000_0000`: reset value of `mtvec`. Bits [1:0] are forced to 0.

**Ports**
- `clk`, input, 1: core clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `instValid`, input, 1: the current instruction commits this cycle.
- `pc`, input, 32: PC of the committing instruction.
- `csrAddr`, input, 12: CSR address (instr[31:20]).
- `rs1Data`, input, 32: rs1 operand.
- `zimm`, input, 5: immediate operand (instr[19:15]).
- `csrWrite`, input, 1: the instruction is a CSR access.
- `csrInstType`, input, 2: CSR operation. 00 = write, 01 = set, 10 = clear, 11 = no write.
- `csrImmInst`, input, 1: 1 selects `{27'b0, zimm}` as the source operand, 0 selects `rs1Data`.
- `ecall`, `ebreak`, `mret`, input, 1 each: strobes from the control unit.
- `irqExt`, `irqTimer`, input, 1 each: level-sensitive interrupt requests.
- `csrReadData`, output, 32: current (pre-write) value of the CSR at `csrAddr`.
- `redirectValid`, output, 1: the PC must be replaced next cycle.
- `redirectPc`, output, 32: redirect target.
- `retire`, output, 1: the instruction retired (it was not displaced by an interrupt).

## Operation

**CSR map.** Unmapped addresses read 0 and ignore writes.
- `mstatus` 0x300: only MIE[3] and MPIE[7] are implemented; all other bits read 0.
- `mie` 0x304: only MEIE[11] and MTIE[7] are implemented.
- `mtvec` 0x305: direct mode only; bits [1:0] always read 0.
- `mscratch` 0x340: full 32 bits.
- `mepc` 0x341: bits [1:0] always read 0.
- `mcause` 0x342: full 32 bits.
- `mip` 0x344: read-only. MEIP[11] = `irqExt`, MTIP[7] = `irqTimer`. Writes are ignored.
- `mcycle` / `mcycleh` 0xB00 / 0xB80: low / high halves of the 64-bit cycle counter. Writable.
- `minstret` / `minstreth` 0xB02 / 0xB82: low / high halves of the 64-bit retired-instruction counter. Writable.

**CSR write.** Performed when `instValid & csrWrite & ~intTake`.
- Source operand `src` is selected by `csrImmInst`.
- New value: type 00 writes `src`; type 01 writes `old | src`; type 10 writes `old & ~src`; type 11 does not write.
- `csrReadData` always returns `old`, i.e. the value before the write.

**Interrupt take.**
- `intPend = mstatus.MIE & ((irqExt & mie[11]) | (irqTimer & mie[7]))`.
- `intTake = instValid & intPend`. The interrupt is taken instead of the committing instruction, which does not retire and has no side effects.

**Trap and return priority**, highest first:
1. External interrupt: `mcause = 32'h8000_000B`.
2. Timer interrupt: `mcause = 32'h8000_0007`.
3. `ebreak`: `mcause = 3`.
4. `ecall`: `mcause = 11`.
5. `mret`.

**Trap entry** (any of items 1–4):
- `mepc <= {pc[31:2], 2'b00}` and `mcause` as above.
- `MPIE <= MIE`, `MIE <= 0`.
- `redirectPc = mtvec`, `redirectValid = 1`.

**mret:**
- `MIE <= MPIE`, `MPIE <= 1`.
- `redirectPc = mepc`, `redirectValid = 1`.

**Counters:**
- `mcycle` increments by 1 every cycle while `rst` is low.
- `minstret` increments when `retire = 1`, where `retire = instValid & ~intTake & ~ecall & ~ebreak`.
- Both counters are 64-bit, with carry from the low half into the high half. They wrap from all-ones to 0.
- A CSR write to either half in the same cycle wins over the increment for the whole counter: the written half takes the new value and the other half holds its value.

## Timing

- `csrReadData`, `redirectValid`, `redirectPc` and `retire` are combinational from inputs and current state, in the same cycle as `instValid`. The fetch stage samples the redirect on the next rising edge.
- All CSR and counter updates take effect at the rising edge ending the commit cycle. A read in the following cycle sees the new value.
- While `rst` is high:
  - `redirectValid = 0`, `retire = 0`.
  - `csrReadData` reflects the reset state.
  - All CSRs are 0 except `mtvec = RESET_MTVEC`; both counters are 0.
- Reset asserted mid-operation discards any in-flight write or trap update.
- When `instValid` is 0: no CSR writes, no traps, `redirectValid = 0`. `mcycle` still counts.
- A CSR write to `mstatus` that sets MIE affects `intPend` from the next cycle only.
- `ecall`/`ebreak` with `csrWrite` asserted cannot occur from the control unit. If it does, the trap wins and the write is suppressed.

## Test plan

1. **Reset.** Assert `rst` asynchronously mid-cycle → all outputs and CSRs at reset values immediately; read 0x305 returns `RESET_MTVEC & ~3`.
2. **Read-modify-write ops.**
   - csrrw 0x340 with `rs1Data = 32'hDEAD_BEEF` → `csrReadData = 0`; next-cycle read returns `DEADBEEF`.
   - Then csrrsi with `zimm = 5'h10` → returns `DEADBEEF`; new value `DEADBEFF`.
   - Then csrrc with `32'hFF` → new value `DEADBE00`.
3. **ecall and mret.**
   - ecall at `pc = 0x100`, `MIE = 1`, `mtvec = 0x200` → `redirectPc = 0x200`, `mepc = 0x100`, `mcause = 11`, `MIE = 0`, `MPIE = 1`, `retire = 0`.
   - Then mret → `redirectPc = 0x100`, `MIE = 1`.
4. **Interrupt priority.**
   - `mie = 0x880`, `MIE = 1`, `irqExt = irqTimer = 1`, committing csrrw to 0x340 at `pc = 0x40` → `mcause = 0x8000000B`, `mepc = 0x40`, `mscratch` unchanged, `minstret` unchanged.
   - Repeat with `MIE = 0` → no trap; the instruction retires.
5. **Counter wrap and write collision.**
   - Write `mcycle = 32'hFFFF_FFFF` → after 1 cycle `mcycleh` increments by 1 and `mcycle = 0`.
   - Write `minstret` on a retiring cycle → the written value holds; no +1 that cycle.
